// File: rtl/segment_header_encoder.sv
// Segment header encoder: accepts a segment command, emits the packed 32-bit
// header word, then forwards ceil(length/4) datapath words with the unused
// tail bytes of the last word optionally zeroed.
module segment_header_encoder #(
  parameter bit MASK_TAIL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_htype,
  input  logic        cmd_eot,
  input  logic        cmd_eoi,
  input  logic        cmd_last,
  input  logic [3:0]  cmd_sel,
  input  logic [15:0] cmd_length,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        seg_done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  hdr_q, hdr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         tail_q, tail_d;

  logic [CNT_W-1:0]   nwords;
  logic               last_word;
  logic [WORD_W-1:0]  tail_mask;

  // Word count of the incoming command; 17 bits so 0xFFFF yields 16384
  assign nwords = (CNT_W'(cmd_length) + CNT_W'(3)) >> 2;

  // Next-state, handshake and output-word selection
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    tail_d     = tail_q;
    cmd_ready  = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    seg_done   = 1'b0;
    last_word  = (cnt_q == CNT_W'(1));
    tail_mask  = '1;

    if (MASK_TAIL && last_word) begin
      case (tail_q)
        2'd1:    tail_mask = 32'hFF00_0000;
        2'd2:    tail_mask = 32'hFFFF_0000;
        2'd3:    tail_mask = 32'hFFFF_FF00;
        default: tail_mask = '1;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        // Hold off commands while reset is asserted
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          hdr_d   = {cmd_htype, 1'b0, cmd_eot, cmd_eoi, cmd_last,
                     cmd_sel, 3'b000, 1'b1, cmd_length};
          cnt_d   = nwords;
          tail_d  = cmd_length[1:0];
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        dout       = hdr_q;
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (cnt_q == '0) begin
            seg_done = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        dout       = din & tail_mask;
        dout_valid = din_valid;
        din_ready  = dout_ready;
        if (din_valid && dout_ready) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_word) begin
            seg_done = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched header and remaining-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_segment_header_encoder.sv
// Bench for segment_header_encoder: a queue-based model predicts every output
// word for both MASK_TAIL settings; one negedge process checks each transfer.
`timescale 1ns/1ps
module tb_segment_header_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [3:0]  cmd_htype;
  logic        cmd_eot, cmd_eoi, cmd_last;
  logic [3:0]  cmd_sel;
  logic [15:0] cmd_length;
  logic [31:0] din;
  logic        din_valid;
  logic        dout_ready;

  logic        cmd_ready0, din_ready0, dout_valid0, seg_done0;
  logic [31:0] dout0;
  logic        cmd_ready1, din_ready1, dout_valid1, seg_done1;
  logic [31:0] dout1;

  always #5 clk = ~clk;

  segment_header_encoder #(.MASK_TAIL(1'b1)) u_mask (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_htype(cmd_htype), .cmd_eot(cmd_eot), .cmd_eoi(cmd_eoi), .cmd_last(cmd_last),
    .cmd_sel(cmd_sel), .cmd_length(cmd_length), .din(din), .din_valid(din_valid),
    .din_ready(din_ready0), .dout(dout0), .dout_valid(dout_valid0),
    .dout_ready(dout_ready), .seg_done(seg_done0)
  );

  segment_header_encoder #(.MASK_TAIL(1'b0)) u_nomask (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_htype(cmd_htype), .cmd_eot(cmd_eot), .cmd_eoi(cmd_eoi), .cmd_last(cmd_last),
    .cmd_sel(cmd_sel), .cmd_length(cmd_length), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .dout(dout1), .dout_valid(dout_valid1),
    .dout_ready(dout_ready), .seg_done(seg_done1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: expected words (masked / unmasked) and whether each ends a segment
  logic [31:0] exp_w1[$];
  logic [31:0] exp_w0[$];
  bit          exp_done[$];
  // Observed output words, for literal spot checks
  logic [31:0] log_w1[$];
  logic [31:0] log_w0[$];
  // Words the datapath source still has to deliver
  logic [31:0] din_q[$];

  int  done_cnt = 0;
  int  din_cnt  = 0;
  bit  din_xfer_s = 1'b0;
  bit  cmd_xfer_s = 1'b0;
  int  rd_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int  vd_mode = 0;   // 0: source always valid, 1: random gaps
  bit  prev_stall = 1'b0;
  bit  prev_done  = 1'b0;
  logic [31:0] prev_dout = '0;
  logic [31:0] e1, e0;
  bit          ed;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      din_xfer_s = 1'b0;
      cmd_xfer_s = 1'b0;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      din_xfer_s = din_valid && din_ready0;
      cmd_xfer_s = cmd_valid && cmd_ready0;
      if (din_xfer_s) din_cnt++;
      check1("din_ready_bp", din_ready0 && !dout_ready, 1'b0);
      check1("din_ready_bp_nomask", din_ready1 && !dout_ready, 1'b0);
      if (prev_stall) begin
        check1("stall_valid", dout_valid0, 1'b1);
        check32("stall_dout", dout0, prev_dout);
      end
      if (prev_done) check1("cmd_ready_after_done", cmd_ready0, 1'b1);
      if (dout_valid0 && dout_ready) begin
        log_w1.push_back(dout0);
        log_w0.push_back(dout1);
        if (exp_w1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %08h want no word", dout0);
        end else begin
          e1 = exp_w1.pop_front();
          e0 = exp_w0.pop_front();
          ed = exp_done.pop_front();
          check32("dout", dout0, e1);
          check1("valid_nomask", dout_valid1, 1'b1);
          check32("dout_nomask", dout1, e0);
          check1("seg_done", seg_done0, ed);
          check1("seg_done_nomask", seg_done1, ed);
        end
      end else begin
        check1("seg_done_quiet", seg_done0, 1'b0);
      end
      if (seg_done0) done_cnt++;
      prev_stall = dout_valid0 && !dout_ready;
      prev_dout  = dout0;
      prev_done  = seg_done0;
    end
  end

  // Datapath source and downstream-ready driver, just after each rising edge
  always @(posedge clk) begin
    #1;
    if (din_xfer_s) begin
      if (din_q.size() > 0) void'(din_q.pop_front());
      din_valid = 1'b0;
    end
    if (cmd_xfer_s) cmd_valid = 1'b0;
    if (!din_valid && din_q.size() > 0 && (vd_mode == 0 || $urandom_range(1, 0) == 1)) begin
      din       = din_q[0];
      din_valid = 1'b1;
    end
    case (rd_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ~dout_ready;
      default: dout_ready = 1'($urandom_range(1, 0));
    endcase
  end

  task automatic issue_seg(input logic [3:0] ht, input bit eot, input bit eoi, input bit lst,
                           input logic [3:0] sel, input logic [15:0] len,
                           input logic [31:0] w0, input logic [31:0] w1);
    int n, tl;
    logic [31:0] hdr, w, m;
    n  = (int'(len) + 3) / 4;
    tl = int'(len) % 4;
    hdr = (32'(ht) << 28) | (32'(eot) << 26) | (32'(eoi) << 25) | (32'(lst) << 24)
        | (32'(sel) << 20) | 32'h0001_0000 | 32'(len);
    @(posedge clk); #2;
    exp_w1.push_back(hdr);
    exp_w0.push_back(hdr);
    exp_done.push_back(len == 16'd0);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
      din_q.push_back(w);
      m = w;
      if (i == n - 1 && tl != 0) m = w & ~(32'hFFFF_FFFF >> (8 * tl));
      exp_w1.push_back(m);
      exp_w0.push_back(w);
      exp_done.push_back(i == n - 1);
    end
    cmd_htype  = ht;
    cmd_eot    = eot;
    cmd_eoi    = eoi;
    cmd_last   = lst;
    cmd_sel    = sel;
    cmd_length = len;
    cmd_valid  = 1'b1;
  endtask

  task automatic wait_seg(input int nwords);
    for (int c = 0; c < 4 * nwords + 100; c++) begin
      @(negedge clk); #1;
      if (exp_w1.size() == 0) break;
    end
    if (exp_w1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL seg_timeout: %0d words outstanding want 0", exp_w1.size());
      exp_w1.delete();
      exp_w0.delete();
      exp_done.delete();
      din_q.delete();
      cmd_valid = 1'b0;
      din_valid = 1'b0;
    end
  endtask

  task automatic run_seg(input logic [3:0] ht, input bit eot, input bit eoi, input bit lst,
                         input logic [3:0] sel, input logic [15:0] len,
                         input logic [31:0] w0, input logic [31:0] w1);
    issue_seg(ht, eot, eoi, lst, sel, len, w0, w1);
    wait_seg((int'(len) + 3) / 4);
  endtask

  task automatic check_quiet(input string name);
    check1({name, "_cmd_ready"}, cmd_ready0, 1'b0);
    check1({name, "_cmd_ready_nomask"}, cmd_ready1, 1'b0);
    check1({name, "_dout_valid"}, dout_valid0, 1'b0);
    check1({name, "_din_ready"}, din_ready0, 1'b0);
    check1({name, "_seg_done"}, seg_done0, 1'b0);
    check32({name, "_dout"}, dout0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d, dc;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_htype = '0; cmd_eot = 1'b0; cmd_eoi = 1'b0; cmd_last = 1'b0;
    cmd_sel = '0; cmd_length = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check_quiet("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check1("idle_cmd_ready", cmd_ready0, 1'b1);

    // Basic segment, two full words
    b = log_w1.size(); d = done_cnt;
    run_seg(4'h4, 1'b1, 1'b0, 1'b1, 4'h0, 16'd8, 32'h0102_0304, 32'h0506_0708);
    check32("len8_header", log_w1[b], 32'h4501_0008);
    check32("len8_word0", log_w1[b+1], 32'h0102_0304);
    check32("len8_word1", log_w1[b+2], 32'h0506_0708);
    check32("len8_done_count", 32'(done_cnt - d), 32'd1);

    // Partial tail word
    b = log_w1.size();
    run_seg(4'h1, 1'b0, 1'b0, 1'b0, 4'h5, 16'd5, 32'hAABB_CCDD, 32'h1122_3344);
    check32("len5_header", log_w1[b], 32'h1051_0005);
    check32("len5_word0", log_w1[b+1], 32'hAABB_CCDD);
    check32("len5_tail_masked", log_w1[b+2], 32'h1100_0000);
    check32("len5_tail_unmasked", log_w0[b+2], 32'h1122_3344);

    // Zero-length segment with a stray datapath word offered
    @(negedge clk); #1;
    din_q.push_back(32'hDEAD_BEEF);
    b = log_w1.size(); d = done_cnt; dc = din_cnt;
    run_seg(4'hD, 1'b0, 1'b1, 1'b0, 4'h0, 16'd0, 32'h0, 32'h0);
    check32("len0_header", log_w1[b], 32'hD201_0000);
    check32("len0_done_count", 32'(done_cnt - d), 32'd1);
    check32("len0_din_consumed", 32'(din_cnt - dc), 32'd0);
    @(negedge clk); #1;
    din_valid = 1'b0;
    din_q.delete();

    // Backpressure toggling with a gappy source
    rd_mode = 1; vd_mode = 1;
    b = log_w1.size(); d = done_cnt;
    run_seg(4'h3, 1'b1, 1'b1, 1'b0, 4'hA, 16'd16, 32'hCAFE_0001, 32'hCAFE_0002);
    check32("len16_header", log_w1[b], 32'h36A1_0010);
    check32("len16_word_count", 32'(log_w1.size() - b), 32'd5);
    check32("len16_done_count", 32'(done_cnt - d), 32'd1);

    // Random backpressure, three tail bytes kept
    rd_mode = 2; vd_mode = 1;
    b = log_w1.size();
    run_seg(4'h7, 1'b0, 1'b0, 1'b1, 4'hF, 16'd11, 32'h1234_5678, 32'h9ABC_DEF0);
    check32("len11_word_count", 32'(log_w1.size() - b), 32'd4);

    // Maximum length
    rd_mode = 0; vd_mode = 0;
    b = log_w1.size(); d = done_cnt;
    run_seg(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 16'hFFFF, 32'h0, 32'h0);
    check32("max_header", log_w1[b], 32'h0001_FFFF);
    check32("max_word_count", 32'(log_w1.size() - b), 32'd16385);
    check32("max_done_count", 32'(done_cnt - d), 32'd1);
    check32("max_tail_byte", log_w1[b+16384] & 32'h0000_00FF, 32'h0);

    // Reset in the middle of a segment
    b = log_w1.size(); d = done_cnt;
    issue_seg(4'h2, 1'b0, 1'b0, 1'b0, 4'h1, 16'd32, 32'h5555_0000, 32'h5555_0001);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (log_w1.size() >= b + 4) break;
    end
    check32("rst_words_before", 32'(log_w1.size() - b), 32'd4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check_quiet("midrst");
    check32("midrst_done_count", 32'(done_cnt - d), 32'd0);
    exp_w1.delete(); exp_w0.delete(); exp_done.delete();
    din_q.delete();
    din_valid = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check1("post_rst_cmd_ready", cmd_ready0, 1'b1);
    b = log_w1.size(); d = done_cnt;
    run_seg(4'h9, 1'b1, 1'b0, 1'b0, 4'h3, 16'd6, 32'h0A0B_0C0D, 32'h0E0F_1011);
    check32("post_rst_header", log_w1[b], 32'h9431_0006);
    check32("post_rst_tail", log_w1[b+2], 32'h0E0F_0000);
    check32("post_rst_done_count", 32'(done_cnt - d), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
